wallace_csa_pipe: RTL and testbench

// - Pipelined 16x16 Wallace-tree front end for the 32-bit multiplier.
// - Builds partial products, reduces them with 3:2 compressors to two 32-bit rows (sum, carry).
// - Both rows are registered and drive the i_a / i_b inputs of the 32-bit Kogge-Stone adder (c0 = 0).
// - Product = adder o_s; adder o_carry is ignored.
// - Valid/ready handshake on both sides so the multiplier can be stalled from downstream.

---
 rtl/wallace_csa_pipe.sv | 139 +++++++++++++
 tb/tb_wallace_csa_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/wallace_csa_pipe.sv
// Pipelined 16x16 Wallace CSA multiplier front end (modified Baugh-Wooley); emits sum/carry rows for the final adder.
// Latency 2 cycles; valid/ready on both sides, holds up to 2 beats when stalled, o_ready has no path from i_valid.
module wallace_csa_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    input  logic               i_signed,
    input  logic [TAG_W-1:0]   i_tag,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [2*WIDTH-1:0] o_sum,
    output logic [2*WIDTH-1:0] o_carry,
    output logic [TAG_W-1:0]   o_tag
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0]    pp [WIDTH];
    logic [PW-1:0]    l1 [11];
    logic [PW-1:0]    l2 [8];
    logic [PW-1:0]    l3 [6];
    logic [PW-1:0]    l4 [4];
    logic [PW-1:0]    l5 [3];
    logic [PW-1:0]    l6_sum;
    logic [PW-1:0]    l6_carry;

    logic [PW-1:0]    s1_row_q [6];
    logic [PW-1:0]    s1_row_d [6];
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic             s1_vld_q, s1_vld_d;
    logic [PW-1:0]    s2_sum_q, s2_sum_d;
    logic [PW-1:0]    s2_carry_q, s2_carry_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
    logic             s2_vld_q, s2_vld_d;
    logic             s1_adv, s2_adv;

    function automatic void csa(input  logic [PW-1:0] x, input logic [PW-1:0] y,
                                input  logic [PW-1:0] z,
                                output logic [PW-1:0] s, output logic [PW-1:0] c);
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    // Stage 1: partial products and reduction 16 -> 11 -> 8 -> 6
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = '0;
            for (int j = 0; j < WIDTH; j++) begin
                pp[i][i+j] = (i_a[j] & i_b[i])
                           ^ (i_signed & ((i == WIDTH-1) != (j == WIDTH-1)));
            end
        end
        // Baugh-Wooley correction constants ride in row 0, whose upper bits are free
        if (i_signed) begin
            pp[0][WIDTH] = 1'b1;
            pp[0][PW-1]  = 1'b1;
        end
        for (int g = 0; g < 5; g++)
            csa(pp[3*g], pp[3*g+1], pp[3*g+2], l1[2*g], l1[2*g+1]);
        l1[10] = pp[WIDTH-1];
        for (int g = 0; g < 3; g++)
            csa(l1[3*g], l1[3*g+1], l1[3*g+2], l2[2*g], l2[2*g+1]);
        l2[6] = l1[9];
        l2[7] = l1[10];
        for (int g = 0; g < 2; g++)
            csa(l2[3*g], l2[3*g+1], l2[3*g+2], l3[2*g], l3[2*g+1]);
        l3[4] = l2[6];
        l3[5] = l2[7];
    end

    // Stage 2: reduction 6 -> 4 -> 3 -> 2
    always_comb begin
        for (int g = 0; g < 2; g++)
            csa(s1_row_q[3*g], s1_row_q[3*g+1], s1_row_q[3*g+2], l4[2*g], l4[2*g+1]);
        csa(l4[0], l4[1], l4[2], l5[0], l5[1]);
        l5[2] = l4[3];
        csa(l5[0], l5[1], l5[2], l6_sum, l6_carry);
    end

    assign s2_adv  = !s2_vld_q | i_ready;
    assign s1_adv  = !s1_vld_q | s2_adv;
    assign o_ready = s1_adv;

    always_comb begin
        s1_vld_d   = s1_vld_q;
        s1_tag_d   = s1_tag_q;
        for (int k = 0; k < 6; k++) s1_row_d[k] = s1_row_q[k];
        s2_vld_d   = s2_vld_q;
        s2_tag_d   = s2_tag_q;
        s2_sum_d   = s2_sum_q;
        s2_carry_d = s2_carry_q;
        if (s1_adv) begin
            s1_vld_d = i_valid;
            if (i_valid) begin
                for (int k = 0; k < 6; k++) s1_row_d[k] = l3[k];
                s1_tag_d = i_tag;
            end
        end
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_sum_d   = l6_sum;
                s2_carry_d = l6_carry;
                s2_tag_d   = s1_tag_q;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld_q   <= 1'b0;
            s1_tag_q   <= '0;
            for (int k = 0; k < 6; k++) s1_row_q[k] <= '0;
            s2_vld_q   <= 1'b0;
            s2_tag_q   <= '0;
            s2_sum_q   <= '0;
            s2_carry_q <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_tag_q   <= s1_tag_d;
            for (int k = 0; k < 6; k++) s1_row_q[k] <= s1_row_d[k];
            s2_vld_q   <= s2_vld_d;
            s2_tag_q   <= s2_tag_d;
            s2_sum_q   <= s2_sum_d;
            s2_carry_q <= s2_carry_d;
        end
    end

    assign o_valid = s2_vld_q;
    assign o_sum   = s2_sum_q;
    assign o_carry = s2_carry_q;
    assign o_tag   = s2_tag_q;

endmodule

// File: tb/tb_wallace_csa_pipe.sv
// Randomized and directed bench for wallace_csa_pipe against an arithmetic product model with an in-order scoreboard.
module tb_wallace_csa_pipe;
    logic        clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_a, i_b;
    logic        i_signed;
    logic [3:0]  i_tag;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_sum, o_carry;
    logic [3:0]  o_tag;

    wallace_csa_pipe #(.WIDTH(16), .TAG_W(4)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_signed(i_signed), .i_tag(i_tag),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum), .o_carry(o_carry), .o_tag(o_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] prod;
        logic [3:0]  tag;
        int          cyc;
    } beat_t;

    beat_t       q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          delivered = 0;
    logic        acc;
    logic        samp_vld, samp_ordy;
    logic [3:0]  samp_tag;
    logic [31:0] last_prod;
    logic        hold_vld = 1'b0;
    logic [31:0] hold_sum, hold_carry;
    logic [3:0]  hold_tag;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        int          sa, sb;
        logic [31:0] ua, ub;
        if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            return 32'(sa * sb);
        end
        ua = {16'h0, a};
        ub = {16'h0, b};
        return ua * ub;
    endfunction

    // One clock cycle: drive at negedge, check and account transfers just after
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [3:0] t, input logic rdy);
        beat_t       e;
        logic [31:0] psum;
        logic        exp_vld;
        @(negedge clk);
        i_valid = v; i_a = a; i_b = b; i_signed = s; i_tag = t; i_ready = rdy;
        #1;
        chk("o_ready", o_ready, (q.size() < 2) || rdy);
        exp_vld = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        chk("o_valid", o_valid, exp_vld);
        if (hold_vld) begin
            chk("hold_valid", o_valid, 1);
            chk("hold_sum", o_sum, hold_sum);
            chk("hold_carry", o_carry, hold_carry);
            chk("hold_tag", o_tag, hold_tag);
        end
        samp_vld = o_valid; samp_tag = o_tag; samp_ordy = o_ready; acc = 1'b0;
        if (o_valid && rdy) begin
            if (q.size() == 0) chk("spurious_beat", o_valid, 0);
            else begin
                e = q.pop_front();
                psum = o_sum + o_carry;
                chk("product", psum, e.prod);
                chk("tag", o_tag, e.tag);
                last_prod = psum;
                delivered++;
            end
        end
        hold_vld = o_valid && !rdy;
        hold_sum = o_sum; hold_carry = o_carry; hold_tag = o_tag;
        if (v && o_ready) begin
            e.prod = model(a, b, s); e.tag = t; e.cyc = cyc;
            q.push_back(e);
            acc = 1'b1;
        end
        cyc++;
    endtask

    task automatic idle();
        cycle(1'b0, 16'h0, 16'h0, 1'b0, 4'h0, 1'b1);
    endtask

    task automatic one_beat(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [3:0] t, input logic [31:0] exp);
        cycle(1'b1, a, b, s, t, 1'b1);
        idle();
        chk({nm, "_lat1"}, samp_vld, 0);
        idle();
        chk({nm, "_lat2"}, samp_vld, 1);
        chk({nm, "_prod"}, last_prod, exp);
        chk({nm, "_tag"}, samp_tag, t);
    endtask

    logic [15:0] ra, rb;
    int          sent, d0;

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_a = '0; i_b = '0; i_signed = 1'b0;
        i_tag = '0; i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_valid = 1'b1; i_a = 16'($urandom); i_b = 16'($urandom);
            i_signed = k[0]; i_tag = 4'($urandom); i_ready = k[1];
            #1;
            chk("rst_valid", o_valid, 0);
            chk("rst_sum", o_sum, 0);
            chk("rst_carry", o_carry, 0);
            chk("rst_tag", o_tag, 0);
            chk("rst_ready", o_ready, 1);
        end
        @(negedge clk);
        i_valid = 1'b0; i_ready = 1'b1;
        i_rst_n = 1'b1;

        one_beat("u_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 4'd5, 32'hFFFE0001);
        one_beat("s_8000", 16'h8000, 16'h8000, 1'b1, 4'd6, 32'h40000000);
        one_beat("s_m1x1", 16'hFFFF, 16'h0001, 1'b1, 4'd7, 32'hFFFFFFFF);
        one_beat("u_ffx1", 16'hFFFF, 16'h0001, 1'b0, 4'd8, 32'h0000FFFF);
        one_beat("s_7fx80", 16'h7FFF, 16'h8000, 1'b1, 4'd9, 32'hC0008000);

        // Back-to-back with tags 1,2,3
        cycle(1'b1, 16'd3, 16'd5, 1'b0, 4'd1, 1'b1);
        cycle(1'b1, 16'hFFFE, 16'd7, 1'b1, 4'd2, 1'b1);
        cycle(1'b1, 16'h1234, 16'h5678, 1'b0, 4'd3, 1'b1);
        chk("b2b_v0", samp_vld, 1); chk("b2b_t0", samp_tag, 1);
        idle();
        chk("b2b_v1", samp_vld, 1); chk("b2b_t1", samp_tag, 2);
        idle();
        chk("b2b_v2", samp_vld, 1); chk("b2b_t2", samp_tag, 3);
        idle();
        chk("b2b_end", samp_vld, 0);

        // Six-beat stream with a four-cycle downstream stall
        sent = 0; d0 = delivered;
        for (int c = 0; c < 30; c++) begin
            cycle(sent < 6, 16'($urandom), 16'($urandom), 1'($urandom), 4'(sent + 10),
                  !(c >= 2 && c < 6));
            if (c == 2) chk("stall_oready", samp_ordy, 0);
            if (acc) sent++;
        end
        chk("stall_sent", sent, 6);
        chk("stall_delivered", delivered - d0, 6);
        chk("stall_drained", q.size(), 0);

        // Reset with two beats in flight
        cycle(1'b1, 16'h00AA, 16'h0055, 1'b0, 4'd1, 1'b1);
        cycle(1'b1, 16'h8001, 16'h7FFF, 1'b1, 4'd2, 1'b1);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", o_valid, 1);
        i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_ready", o_ready, 1);
        q.delete();
        hold_vld = 1'b0;
        @(negedge clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) idle();

        // Random traffic
        for (int k = 0; k < 10000; k++) begin
            case ($urandom_range(0, 5))
                0: ra = 16'h8000;
                1: ra = 16'hFFFF;
                2: ra = 16'h7FFF;
                default: ra = 16'($urandom);
            endcase
            rb = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            cycle($urandom_range(0, 9) < 7, ra, rb, 1'($urandom), 4'($urandom),
                  $urandom_range(0, 9) < 7);
        end
        for (int k = 0; k < 4; k++) idle();
        chk("final_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
